// File: rtl/mul_rnd_pipe.sv
// mul_rnd_pipe: two-stage pipeline that rounds a signed product to SIZE fractional zeros,
// with optional saturation and overflow flag, sticky bit and saturating counter.
module mul_rnd_pipe #(
    parameter int SIZE = 16,
    parameter int CNT_W = 8,
    localparam int W = SIZE * 5 / 2,
    localparam int U = W - SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     data_in,
    input  logic [1:0]       mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     data_out,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_cnt
);
    logic             adv, in_inc, s1_valid, s1_inc, s1_sat, ovf_d, fire_ovf;
    logic [1:0]       s1_mode;
    logic [W-1:0]     s1_data, res;
    logic [U-1:0]     s1_upper, sum, max_pos;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    // ties-to-even: a bare half only rounds up when the kept LSB is odd
    assign in_inc   = mode == 2'b10 ? data_in[SIZE-1] & ((|data_in[SIZE-2:0]) | data_in[SIZE]) :
                      mode == 2'b11 ? data_in[SIZE-1] : 1'b0;
    assign max_pos  = {1'b0, {(U-1){1'b1}}};
    assign s1_upper = s1_data[W-1:SIZE];
    assign sum      = s1_upper + {{(U-1){1'b0}}, s1_inc};
    assign ovf_d    = s1_inc & (s1_upper == max_pos);
    assign res      = s1_mode == 2'b00 ? s1_data : {(ovf_d & s1_sat) ? max_pos : sum, {SIZE{1'b0}}};
    assign fire_ovf = out_valid & out_ready & ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'b00;
            s1_sat   <= 1'b0;
            s1_inc   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_data  <= data_in;
            s1_mode  <= mode;
            s1_sat   <= sat_en;
            s1_inc   <= in_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            data_out  <= res;
            ovf       <= ovf_d & s1_valid;
        end
    end

    // a clear colliding with an overflowed transfer leaves exactly that one event recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (ovf_clr) begin
            ovf_sticky <= fire_ovf;
            ovf_cnt    <= CNT_W'(fire_ovf);
        end else if (fire_ovf) begin
            ovf_sticky <= 1'b1;
            ovf_cnt    <= ovf_cnt == '1 ? ovf_cnt : ovf_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/mul_rnd_pipe.md
MUL_RND_PIPE -- requirements
Module: mul_rnd_pipe

Interface
REQ-001 The module SHALL have parameter SIZE, default 16, giving the fraction width; SIZE SHALL be even and at least 4.
REQ-002 The module SHALL have derived widths W = SIZE*5/2 (data width) and U = W-SIZE (upper-field width).
REQ-003 The module SHALL have parameter CNT_W, default 8, giving the overflow-counter width.
REQ-004 The module SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- data_in  input  W  signed two's-complement multiplier product.
- mode  input  2  rounding mode: 00 pass, 01 truncate, 10 round-half-even, 11 round-half-up.
- sat_en  input  1  clamp on rounding overflow instead of wrapping.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- data_out  output  W  rounded result.
- ovf  output  1  the current result overflowed during rounding.
- ovf_sticky  output  1  an overflow has occurred since the last clear.
- ovf_clr  input  1  synchronous clear of ovf_sticky and ovf_cnt.
- ovf_cnt  output  CNT_W  saturating count of overflowed results.

Function
REQ-005 The datapath SHALL be two register stages: S1 captures data_in, mode and sat_en and computes the increment decision; S2 holds the added and saturated result.
REQ-006 A beat SHALL transfer in when in_valid and in_ready are both 1, and SHALL transfer out when out_valid and out_ready are both 1.
REQ-007 The global advance signal SHALL be adv = ~out_valid | out_ready, and in_ready SHALL equal adv.
REQ-008 On a cycle with adv = 1, S1 SHALL load the input beat (S1 valid := in_valid), and S2 SHALL load S1 (S2 valid := S1 valid).
REQ-009 On a cycle with adv = 0, both stages SHALL hold all contents unchanged.
REQ-010 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when there is no backpressure, with a sustained throughput of 1 beat per cycle.
REQ-011 data_out, ovf and out_valid SHALL be driven only from S2 registers.
REQ-012 The fields of a beat SHALL be named as follows: upper = data[W-1:SIZE], guard = data[SIZE-1], rest = data[SIZE-2:0], lsbU = data[SIZE].
REQ-013 Mode 00 SHALL output data_in unchanged, with ovf = 0.
REQ-014 Mode 01 SHALL output {upper, SIZE zeros}.
REQ-015 Mode 10 SHALL use increment inc = guard & (rest != 0 | lsbU), which rounds to nearest with ties to even.
REQ-016 Mode 11 SHALL use increment inc = guard.
REQ-017 For modes 10 and 11, the sum SHALL be upper + inc in U bits, and the output SHALL be {sum, SIZE zeros}.
REQ-018 An overflow SHALL be flagged when inc = 1 and upper = 0 followed by U-1 ones (the maximum positive value); ovf SHALL be 1 for that result.
REQ-019 On overflow with sat_en = 1, the output SHALL be {0, U-1 ones, SIZE zeros}.
REQ-020 On overflow with sat_en = 0, the output SHALL wrap to {1, U-1 zeros, SIZE zeros}.
REQ-021 Negative values SHALL never overflow, because the increment is always non-negative.
REQ-022 ovf_sticky SHALL set, and ovf_cnt SHALL increment, on the cycle an overflowed beat is transferred out.
REQ-023 ovf_cnt SHALL saturate at all-ones.
REQ-024 ovf_clr SHALL clear ovf_sticky and ovf_cnt on the next clock edge.
REQ-025 When ovf_clr coincides with an overflowed output transfer, the result SHALL be ovf_sticky = 1 and ovf_cnt = 1.
REQ-026 mode and sat_en SHALL be sampled only with an accepted beat; changing them mid-pipeline SHALL NOT affect beats already in flight.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force S1 valid = 0, out_valid = 0, data_out = 0, ovf = 0, ovf_sticky = 0 and ovf_cnt = 0.
REQ-028 in_ready SHALL equal 1 while rst_n is low and after reset is released.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats without producing an output transfer.
REQ-030 Reset release SHALL be synchronous to clk, and the first beat SHALL be accepted on the first edge after release.

Verification
REQ-031 (SIZE=16, out_ready=1) The bench SHALL cover rounding: mode 10 with 0x0000038000 -> 0x0000040000 two cycles later; mode 10 with 0x0000028000 -> 0x0000020000; mode 11 with 0x0000028000 -> 0x0000030000.
REQ-032 The bench SHALL cover overflow: mode 10, sat_en=1, 0x7FFFFF8001 -> 0x7FFFFF0000 with ovf=1, ovf_sticky=1 and ovf_cnt=1; the same input with sat_en=0 -> 0x8000000000 with ovf=1.
REQ-033 The bench SHALL cover pass and truncate: mode 00 with 0xFFFFFF8001 -> 0xFFFFFF8001; mode 01 with the same input -> 0xFFFFFF0000 with ovf=0.
REQ-034 The bench SHALL cover backpressure: stream 4 beats with out_ready held 0 for 3 cycles after the first out_valid; data_out SHALL stay stable, in_ready SHALL be 0 while stalled, and all 4 results SHALL appear in order with none lost or duplicated.
REQ-035 The bench SHALL cover clear collision: pulse ovf_clr on the same cycle an overflowed beat transfers out -> ovf_sticky=1 and ovf_cnt=1; with CNT_W=2 and 5 overflows -> ovf_cnt=3.
REQ-036 The bench SHALL cover reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid=0 immediately with no output transfer, and the next accepted beat completes normally with a latency of 2 cycles.
